// File: rtl/adc_share_arbiter_if.sv
// Bus bundle between adc_share_arbiter, the shared converter front end and
// the requesting consumer units. The arbiter takes the master modport.
interface adc_share_arbiter_if #(
  parameter int N = 3
);
  logic [N-1:0] req;
  logic [1:0]   sel;
  logic         soc;
  logic         eoc;
  logic [7:0]   x;
  logic [7:0]   data;
  logic [N-1:0] dav_;
  logic [N-1:0] rfd;
  logic         busy;
  logic         tmo;

  modport master (
    input  req, eoc, x, rfd,
    output sel, soc, data, dav_, busy, tmo
  );

  modport slave (
    output req, eoc, x, rfd,
    input  sel, soc, data, dav_, busy, tmo
  );
endinterface

// File: rtl/adc_share_arbiter.sv
// adc_share_arbiter: round-robin sharing of one soc/eoc A/D converter among
// N requesters. One conversion per grant; the result is handed to the winner
// over a dav_/rfd handshake. All outputs are registered.
// Optional conversion watchdog: define ADC_TMO_EN to build it.
module adc_share_arbiter #(
  parameter int N          = 3,
  parameter int TMO_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  adc_share_arbiter_if.master bus
);

  localparam logic [2:0]   ST_IDLE   = 3'd0;
  localparam logic [2:0]   ST_SOC_H  = 3'd1;
  localparam logic [2:0]   ST_CONV   = 3'd2;
  localparam logic [2:0]   ST_WAIT0  = 3'd3;
  localparam logic [2:0]   ST_WAIT1  = 3'd4;
  localparam logic [1:0]   LAST_INIT = 2'(N - 1);
  localparam logic [N-1:0] DAV_IDLE  = {N{1'b1}};

  if ((N < 2) || (N > 4) || (TMO_CYCLES < 1)) begin : g_bad_cfg
    $error("adc_share_arbiter: unsupported parameter values");
  end

  logic [2:0]   state_r;
  logic [1:0]   last_r;
  logic [1:0]   sel_r;
  logic         soc_r;
  logic         busy_r;
  logic [7:0]   data_r;
  logic [N-1:0] dav_r;
  logic [1:0]   grant_s;
  logic         rfd_sel_s;
  logic         wd_hit_s;
  logic         abort_s;

  // Next requester after 'last' (modulo N) whose request bit is set.
  function automatic logic [1:0] rr_pick(input logic [N-1:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [2:0] sum;
    logic [2:0] idx;
    pick = last;
    // Walk from farthest to nearest so the nearest set bit wins.
    for (int i = N; i >= 1; i--) begin
      sum  = 3'(last) + 3'(i);
      idx  = (sum >= 3'(N)) ? (sum - 3'(N)) : sum;
      pick = r[idx[1:0]] ? idx[1:0] : pick;
    end
    return pick;
  endfunction

  // dav_ pattern with only the given requester's bit pulled low.
  function automatic logic [N-1:0] dav_low(input logic [1:0] idx);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (2'(i) == idx) ? 1'b0 : 1'b1;
    end
    return v;
  endfunction

  // Grant candidate and the granted requester's ready line.
  always_comb begin
    grant_s   = rr_pick(bus.req, last_r);
    rfd_sel_s = bus.rfd[sel_r];
  end

`ifdef ADC_TMO_EN
  logic [15:0] wd_cnt_r;
  logic        tmo_r;

  assign wd_hit_s = (wd_cnt_r >= 16'(TMO_CYCLES - 1));

  // Watchdog counter: cleared while idle (so on grant), counts converter wait clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      wd_cnt_r <= 16'd0;
    end else if ((state_r == ST_SOC_H) || (state_r == ST_CONV)) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Abort flag: set by a watchdog expiry, cleared when the handshake releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_r <= 1'b0;
    end else if (abort_s) begin
      tmo_r <= 1'b1;
    end else if ((state_r == ST_WAIT1) && rfd_sel_s) begin
      tmo_r <= 1'b0;
    end else begin
      tmo_r <= tmo_r;
    end
  end

  assign bus.tmo = tmo_r;
`else
  assign wd_hit_s = 1'b0;
  assign bus.tmo  = 1'b0;
`endif

  // A real eoc in CONV on the expiry edge wins over the abort.
  always_comb begin
    abort_s = 1'b0;
    case (state_r)
      ST_SOC_H: abort_s = wd_hit_s;
      ST_CONV:  abort_s = wd_hit_s && !bus.eoc;
      default:  abort_s = 1'b0;
    endcase
  end

  // Arbitration, converter handshake and result delivery sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      soc_r   <= 1'b0;
      dav_r   <= DAV_IDLE;
      sel_r   <= 2'd0;
      data_r  <= 8'd0;
      busy_r  <= 1'b0;
      last_r  <= LAST_INIT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            sel_r   <= grant_s;
            busy_r  <= 1'b1;
            soc_r   <= 1'b1;
            state_r <= ST_SOC_H;
          end
        end
        ST_SOC_H: begin
          if (abort_s) begin
            soc_r   <= 1'b0;
            data_r  <= 8'hFF;
            dav_r   <= dav_low(sel_r);
            state_r <= ST_WAIT0;
          end else if (!bus.eoc) begin
            soc_r   <= 1'b0;
            state_r <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bus.eoc) begin
            data_r  <= bus.x;
            dav_r   <= dav_low(sel_r);
            state_r <= ST_WAIT0;
          end else if (abort_s) begin
            soc_r   <= 1'b0;
            data_r  <= 8'hFF;
            dav_r   <= dav_low(sel_r);
            state_r <= ST_WAIT0;
          end
        end
        ST_WAIT0: begin
          if (!rfd_sel_s) begin
            dav_r   <= DAV_IDLE;
            state_r <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          if (rfd_sel_s) begin
            last_r  <= sel_r;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: drop back to a quiet idle.
          state_r <= ST_IDLE;
          soc_r   <= 1'b0;
          dav_r   <= DAV_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel  = sel_r;
  assign bus.soc  = soc_r;
  assign bus.data = data_r;
  assign bus.dav_ = dav_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Self-checking bench for adc_share_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model kept below.
module tb_adc_share_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  adc_share_arbiter_if #(.N(N)) bus ();

  adc_share_arbiter #(.N(N), .TMO_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: one grant = ordered list of four events (eoc low, eoc high,
  // rfd low, rfd high); m_step is the index of the next awaited event.
  bit         m_active = 1'b0;
  int         m_step   = 0;
  int         m_sel    = 0;
  int         m_last   = N - 1;
  logic [7:0] m_data   = 8'd0;
  bit         m_tmo    = 1'b0;
  int         m_wd     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit abort;
    abort = 1'b0;
    if (reset) begin
      m_active = 1'b0; m_step = 0; m_sel = 0; m_last = N - 1;
      m_data = 8'd0; m_tmo = 1'b0; m_wd = 0;
    end else if (!m_active) begin
      if (bus.req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (bus.req[(m_last + k) % N]) begin
            m_sel = (m_last + k) % N;
            break;
          end
        end
        m_active = 1'b1; m_step = 0; m_wd = 0;
      end
    end else begin
`ifdef ADC_TMO_EN
      if (m_step < 2) begin
        m_wd++;
        if (!(m_step == 1 && bus.eoc) && m_wd >= TMO) abort = 1'b1;
      end
`endif
      if (abort) begin
        m_data = 8'hFF; m_tmo = 1'b1; m_step = 2;
      end else begin
        case (m_step)
          0: if (!bus.eoc) m_step = 1;
          1: if (bus.eoc) begin m_data = bus.x; m_step = 2; end
          2: if (!bus.rfd[m_sel]) m_step = 3;
          3: if (bus.rfd[m_sel]) begin m_active = 1'b0; m_last = m_sel; m_tmo = 1'b0; end
          default: ;
        endcase
      end
    end
  endtask

  // Model advances on each active edge using the inputs the DUT sees.
  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic [N-1:0] e_dav;
    @(negedge clock);
    if (chk_en) begin
      e_dav = '1;
      if (m_active && m_step == 2) e_dav[m_sel] = 1'b0;
      check("model sel",  32'(bus.sel),  32'(m_sel));
      check("model soc",  32'(bus.soc),  32'(m_active && m_step == 0));
      check("model data", 32'(bus.data), 32'(m_data));
      check("model dav_", 32'(bus.dav_), 32'(e_dav));
      check("model busy", 32'(bus.busy), 32'(m_active));
      check("model tmo",  32'(bus.tmo),  32'(m_tmo));
    end
  end

  task automatic step_clk();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
  endtask

  task automatic wait_soc(input int exp_sel, input string tag);
    int n;
    n = 0;
    while (bus.soc !== 1'b1 && n < 30) begin
      step_clk();
      n++;
    end
    check({tag, " soc"}, 32'(bus.soc), 32'd1);
    check({tag, " sel"}, 32'(bus.sel), 32'(exp_sel));
  endtask

  task automatic run_conv(input logic [7:0] xv, input int low_dly, input int high_dly);
    for (int i = 0; i < low_dly; i++) step_clk();
    bus.eoc = 1'b0;
    bus.x   = xv;
    step_clk();
    check("conv soc low", 32'(bus.soc), 32'd0);
    for (int i = 1; i < high_dly; i++) step_clk();
    bus.eoc = 1'b1;
  endtask

  task automatic wait_dav(input logic [N-1:0] exp_dav, input logic [7:0] exp_data, input string tag);
    int n;
    n = 0;
    while (bus.dav_ === {N{1'b1}} && n < 30) begin
      step_clk();
      n++;
    end
    check({tag, " dav_"}, 32'(bus.dav_), 32'(exp_dav));
    check({tag, " data"}, 32'(bus.data), 32'(exp_data));
  endtask

  task automatic consume(input int stall, input int g, input logic [N-1:0] exp_dav,
                         input logic [7:0] exp_data, input string tag);
    for (int i = 0; i < stall; i++) begin
      step_clk();
      check({tag, " stall dav_"}, 32'(bus.dav_), 32'(exp_dav));
      check({tag, " stall data"}, 32'(bus.data), 32'(exp_data));
      check({tag, " stall soc"},  32'(bus.soc),  32'd0);
    end
    bus.rfd[g] = 1'b0;
    step_clk();
    check({tag, " released dav_"}, 32'(bus.dav_), 32'(3'b111));
    check({tag, " busy held"},     32'(bus.busy), 32'd1);
    bus.rfd = '1;
    step_clk();
    check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
  endtask

  logic [7:0] rr_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int p_eoc;
  int p_rfd;

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.eoc = 1'b1;
    bus.x   = 8'd0;
    bus.rfd = '1;
    step_clk();
    step_clk();
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      step_clk();
      check("idle soc",  32'(bus.soc),  32'd0);
      check("idle dav_", 32'(bus.dav_), 32'(3'b111));
      check("idle busy", 32'(bus.busy), 32'd0);
      check("idle sel",  32'(bus.sel),  32'd0);
    end

    // Single request from requester 1.
    bus.req = 3'b010;
    wait_soc(1, "single");
    bus.req = 3'b000;
    run_conv(8'h5A, 2, 4);
    wait_dav(3'b101, 8'h5A, "single");
    consume(0, 1, 3'b101, 8'h5A, "single");

    // Round-robin with all requests held: 0,1,2 then wrap to 0.
    pulse_reset();
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] ed;
      ed = '1;
      ed[i % 3] = 1'b0;
      wait_soc(i % 3, "rr");
      run_conv(rr_vals[i], 1, 2);
      wait_dav(ed, rr_vals[i], "rr");
      consume(0, i % 3, ed, rr_vals[i], "rr");
    end
    bus.req = 3'b000;

    // Stalled consumer: requester 2 must wait for requester 0's release.
    pulse_reset();
    bus.req = 3'b101;
    wait_soc(0, "stall");
    run_conv(8'hC3, 1, 1);
    wait_dav(3'b110, 8'hC3, "stall");
    consume(20, 0, 3'b110, 8'hC3, "stall");
    wait_soc(2, "stall next");
    run_conv(8'h3C, 1, 1);
    wait_dav(3'b011, 8'h3C, "stall next");
    bus.req = 3'b000;
    consume(0, 2, 3'b011, 8'h3C, "stall next");

    // Reset in the middle of a conversion.
    bus.req = 3'b001;
    wait_soc(0, "midrst");
    bus.req = 3'b000;
    bus.eoc = 1'b0;
    step_clk();
    step_clk();
    reset = 1'b1;
    step_clk();
    check("midrst soc",  32'(bus.soc),  32'd0);
    check("midrst dav_", 32'(bus.dav_), 32'(3'b111));
    check("midrst busy", 32'(bus.busy), 32'd0);
    reset   = 1'b0;
    bus.eoc = 1'b1;
    bus.req = 3'b001;
    wait_soc(0, "after rst");
    bus.req = 3'b000;
    run_conv(8'h77, 1, 1);
    wait_dav(3'b110, 8'h77, "after rst");
    consume(0, 0, 3'b110, 8'h77, "after rst");

    // Converter that never finishes.
    bus.req = 3'b100;
    wait_soc(2, "wdog");
    bus.req = 3'b000;
    bus.eoc = 1'b0;
`ifdef ADC_TMO_EN
    wait_dav(3'b011, 8'hFF, "wdog");
    check("wdog tmo", 32'(bus.tmo), 32'd1);
    consume(0, 2, 3'b011, 8'hFF, "wdog");
    check("wdog tmo clear", 32'(bus.tmo), 32'd0);
    bus.eoc = 1'b1;
`else
    for (int i = 0; i < 40; i++) begin
      step_clk();
      check("hang busy", 32'(bus.busy), 32'd1);
      check("hang dav_", 32'(bus.dav_), 32'(3'b111));
      check("hang tmo",  32'(bus.tmo),  32'd0);
    end
    bus.eoc = 1'b1;
    pulse_reset();
`endif

    // Randomized traffic, checked by the model every cycle.
    p_eoc = 4;
    p_rfd = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        p_eoc = $urandom_range(1, 7);
        p_rfd = $urandom_range(1, 7);
      end
      reset   = ($urandom_range(0, 299) == 0);
      bus.req = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      bus.eoc = ($urandom_range(0, 7) < p_eoc);
      for (int b = 0; b < N; b++) bus.rfd[b] = ($urandom_range(0, 7) < p_rfd);
      bus.x   = 8'($urandom);
      step_clk();
    end
    reset   = 1'b0;
    bus.req = '0;
    step_clk();
    step_clk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_share_arbiter.md
Name: adc_share_arbiter

Overview:
- Shares one soc/eoc-handshaked A/D converter among N requesters.
- Picks a requester round-robin and drives the analog channel select.
- Runs one full soc/eoc conversion, captures the 8-bit result, and hands it to the winning requester over a dav_/rfd handshake.
- Sits between the converter front end and the consumer units that currently talk to the converter directly.

Parameters:
- N, 3, number of requesters; legal range 2..4.
- TMO_CYCLES, 64, conversion watchdog limit in clocks; used only with ADC_TMO_EN.

Ports:
- clock  in  1  system clock; all activity on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  level request, one bit per requester.
- sel  out  2  analog mux channel select = index of the granted requester.
- soc  out  1  start-of-conversion to the converter.
- eoc  in  1  end-of-conversion from the converter.
- x  in  8  converter result.
- data  out  8  result bus, shared by all requesters.
- dav_  out  N  per-requester data-valid, active low.
- rfd  in  N  per-requester ready-for-data, active high.
- busy  out  1  high from grant until release completes.
- tmo  out  1  result on data is a watchdog abort; constant 0 without ADC_TMO_EN.

Behaviour:
- Outputs: all outputs are registered; at most one dav_ bit is low at any time.
- Reset (any cycle, including mid-conversion or mid-handshake): on the next posedge
  - state=IDLE, soc=0, dav_=all 1, sel=0, data=0, busy=0, tmo=0;
  - round-robin pointer LAST=N-1, so requester 0 wins first.
  - An in-flight converter cycle is simply abandoned.
- IDLE:
  - req is sampled here only. With no bit set, stay in IDLE.
  - Otherwise grant G = first set bit searching LAST+1, LAST+2, ... modulo N.
  - Registered in one edge: sel<=G, busy<=1, soc<=1, go SOC_H.
  - Latency from req to soc=1 is 1 clock.
- SOC_H: hold soc=1; on eoc==0 set soc<=0 and go CONV; else stay.
- CONV: on eoc==1 set data<=x, dav_[G]<=0 and go WAIT0; else stay.
- WAIT0: on rfd[G]==0 set dav_[G]<=1 and go WAIT1.
- WAIT1: on rfd[G]==1 set LAST<=G, busy<=0, tmo<=0 and go IDLE.
- Stability: sel and data stay stable from grant until WAIT1 exits. req changes after grant are ignored; a dropped req does not cancel the conversion.
- rfd of non-granted requesters is ignored.
- Back-to-back requests:
  - The next grant is evaluated in the IDLE cycle after release.
  - Each grant costs a minimum of 5 clocks when converter and consumer answer immediately.
- Fairness: a requester holding req continuously is served within N grants.
- Width: sel is 2 bits for every legal N; index arithmetic is modulo N, not modulo 4.

Optional Feature:
- Macro: ADC_TMO_EN.
- When defined:
  - A 16-bit counter clears on grant and counts every clock in SOC_H and CONV.
  - If it reaches TMO_CYCLES before CONV exits: soc<=0, data<=8'hFF, tmo<=1, dav_[G]<=0, go WAIT0.
  - The normal handshake then completes, and tmo clears in WAIT1.
  - A normal eoc completion on the same edge as the limit takes priority: real data is delivered, tmo=0.
- When undefined: no counter is built, SOC_H and CONV wait forever, and tmo is tied to 0.

Test Plan:
- Reset then idle: after reset with req=0 for 10 clocks, require soc=0, dav_=3'b111, busy=0, sel=0 throughout.
- Single request: req=3'b010 with converter model (eoc low 2 clocks after soc, high 4 clocks later, x=8'h5A) and an immediate consumer. Require sel=1, one soc pulse, data=8'h5A, dav_ = 3'b101 until rfd[1]=0, then busy falls after rfd[1]=1.
- Round-robin: req=3'b111 held with three consecutive conversions of x=8'h11, 8'h22, 8'h33. Require grant order 0,1,2; each requester receives its value; then order wraps to 0.
- Stalled consumer: hold rfd[0]=1 for 20 clocks after dav_[0]=0. Require dav_[0] held low, data stable, no new soc, and req[2] not granted until release.
- Reset mid-conversion: assert reset for 1 clock while in CONV. Require soc=0, dav_ all 1, busy=0 next edge. A subsequent req=3'b001 is granted to requester 0.
- Watchdog (ADC_TMO_EN, TMO_CYCLES=8): eoc never returns high. Require after 8 counted clocks data=8'hFF, tmo=1, dav_[G]=0; after the handshake, return to IDLE with tmo=0. Without the macro, the same stimulus leaves the block in CONV indefinitely.
